// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin shared shift-add 3x4 multiplier built on one 4-bit ripple-carry adder
module mult_share_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [2:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [6:0] mul
);
  typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, DONE} state_t;
  state_t state, state_nxt;
  logic       pri, id, sel;
  logic [2:0] a;
  logic [3:0] b, win, sum;
  logic [4:0] cy;
  logic [6:0] acc, acc_nxt;
  logic [1:0] step;
  assign sel  = (req0 & req1) ? pri : req1;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nxt = state;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      IDLE: if (!rst && (req0 | req1)) begin
        gnt0 = ~sel;
        gnt1 = sel;
        state_nxt = ADD0;
      end
      ADD0:    state_nxt = ADD1;
      ADD1:    state_nxt = ADD2;
      ADD2:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  assign step = state == ADD1 ? 2'd1 : state == ADD2 ? 2'd2 : 2'd0;
  // bits above the adder window are always zero here, so the carry lands directly at bit step+4
  assign win   = 4'(acc >> step);
  assign cy[0] = 1'b0;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = win[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (win[i] & b[i]) | (cy[i] & (win[i] ^ b[i]));
  end
  assign acc_nxt = a[step] ? (acc & ~(7'h7f << step)) | (7'({cy[4], sum}) << step) : acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pri     <= 1'b0;
      id      <= 1'b0;
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      mul     <= '0;
      done_id <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt0 | gnt1) begin
        a   <= sel ? a1 : a0;
        b   <= sel ? b1 : b0;
        id  <= sel;
        pri <= ~sel;
        acc <= '0;
      end else if (state inside {ADD0, ADD1, ADD2}) begin
        acc <= acc_nxt;
      end
      if (state == ADD2) begin
        mul     <= acc_nxt;
        done_id <= id;
      end
    end
  end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: scoreboard bench, drivers push expected products, monitor checks on done
module tb_mult_share_ctrl;
  logic       clk = 1'b0, rst = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic [2:0] a0 = '0, a1 = '0;
  logic [3:0] b0 = '0, b1 = '0;
  logic       gnt0, gnt1, busy, done, done_id;
  logic [6:0] mul;
  typedef struct {bit id; logic [6:0] mul; int due;} exp_t;
  exp_t q[$];
  int cyc = 0, tests = 0, fails = 0, g0, g1, g;

  mult_share_ctrl dut (
    .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id), .mul(mul)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    chk("gnt_onehot", gnt0 & gnt1, 0);
    chk("gnt_idle_only", (gnt0 | gnt1) & busy, 0);
    if (done) begin
      if (q.size() == 0) chk("spurious_done", done, 0);
      else begin
        e = q.pop_front();
        chk("mul", mul, e.mul);
        chk("done_id", done_id, e.id);
        chk("latency", cyc, e.due);
      end
    end else if (q.size() > 0 && cyc > q[0].due) begin
      chk("done_missing", done, 1);
      void'(q.pop_front());
    end
  end

  task automatic issue(input bit id, input logic [2:0] a, input logic [3:0] b,
                       input logic [6:0] m, input bit chg, output int gc);
    @(posedge clk); #1;
    if (id) begin req1 = 1; a1 = a; b1 = b; end
    else begin req0 = 1; a0 = a; b0 = b; end
    gc = -1;
    for (int k = 0; k < 20 && gc < 0; k++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) begin
        gc = cyc;
        q.push_back('{id, m, cyc + 4});
      end
    end
    if (gc < 0) chk("gnt_timeout", id ? gnt1 : gnt0, 1);
    @(posedge clk); #1;
    if (id) req1 = 0; else req0 = 0;
    if (chg) begin if (id) a1 = 7; else a0 = 7; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    req0 = 1; req1 = 1; a0 = 3; b0 = 5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mul", mul, 0);
    chk("rst_done_id", done_id, 0);
    @(posedge clk); #1 req0 = 0; req1 = 0; rst = 0;
    issue(0, 3'd3, 4'd5, 7'd15, 0, g);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_in_op", busy, 1);
    end
    @(negedge clk);
    chk("busy_after", busy, 0);
    issue(1, 3'd7, 4'd15, 7'd105, 0, g);
    idle(6);
    do_reset();
    fork
      issue(0, 3'd5, 4'd13, 7'd65, 0, g0);
      issue(1, 3'd6, 4'd11, 7'd66, 0, g1);
    join
    chk("rr_gap", g1 - g0, 5);
    idle(6);
    @(posedge clk); #1 req0 = 1; a0 = 7; b0 = 9;
    g = -1;
    for (int k = 0; k < 20 && g < 0; k++) begin
      @(negedge clk);
      if (gnt0) g = cyc;
    end
    if (g < 0) chk("abort_gnt_timeout", gnt0, 1);
    @(posedge clk); #1 req0 = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_mul", mul, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    issue(0, 3'd7, 4'd9, 7'd63, 0, g);
    idle(6);
    issue(0, 3'd0, 4'd15, 7'd0, 1, g);
    idle(5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_mul0", mul, 0);
      chk("hold_no_done", done, 0);
    end
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 16; b++)
        issue(0, 3'(a), 4'(b), 7'(a * b), 0, g);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_share_ctrl.md
MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset: clk is the sole clock and rst the sole reset, sampled on posedge clk.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: req0  input  1  requester 0 multiply request; held high until gnt0.
REQ-005 Port: a0  input  3  requester 0 multiplier operand (unsigned).
REQ-006 Port: b0  input  4  requester 0 multiplicand operand (unsigned).
REQ-007 Port: req1  input  1  requester 1 multiply request; held high until gnt1.
REQ-008 Port: a1  input  3  requester 1 multiplier operand (unsigned).
REQ-009 Port: b1  input  4  requester 1 multiplicand operand (unsigned).
REQ-010 Port: gnt0  output  1  one-cycle accept pulse for requester 0.
REQ-011 Port: gnt1  output  1  one-cycle accept pulse for requester 1.
REQ-012 Port: busy  output  1  high in every non-IDLE state.
REQ-013 Port: done  output  1  one-cycle result-valid pulse.
REQ-014 Port: done_id  output  1  requester owning the current result (0/1).
REQ-015 Port: mul  output  7  unsigned product a*b, range 0..105.

Function
REQ-016 The block SHALL be built around one shared 4-bit ripple-carry adder, used iteratively in shift-add fashion; no combinational array multiplier.
REQ-017 FSM states SHALL be: IDLE, ADD0, ADD1, ADD2, DONE.
REQ-018 IDLE: when req0 or req1 is high, assert the selected gnt combinationally in that same cycle, latch that requester's a/b and id, clear the accumulator, and go to ADD0; otherwise remain in IDLE.
REQ-019 Arbitration SHALL be round-robin:
- with a single request, that requester wins;
- with both requests, the requester not served last wins;
- after reset, requester 0 has priority.
REQ-020 At most one gnt SHALL be high in any cycle, and gnt SHALL never be high outside IDLE.
REQ-021 In ADDi (i=0,1,2) the accumulator SHALL add b<<i when latched a[i]=1 and hold otherwise; full 7-bit width, no overflow possible.
REQ-022 DONE: mul SHALL take the accumulator value, done=1 for exactly that cycle, done_id = latched id; next state is IDLE.
REQ-023 Latency SHALL be fixed: gnt in cycle T -> done in cycle T+4. The earliest next gnt is T+5, giving a throughput of one product per 5 cycles.
REQ-024 mul and done_id SHALL hold their values from the last DONE until the next DONE.
REQ-025 Requests arriving while busy SHALL be ignored until IDLE; they are not queued, and the requester keeps req asserted.
REQ-026 A req deasserted before its gnt SHALL cause no transaction and no state change.
REQ-027 Operand changes after gnt SHALL NOT affect the in-flight result.
REQ-028 Operand a=0 or b=0 SHALL still take the full 4-cycle sequence and produce mul=0.

Reset
REQ-029 With rst high at a clock edge:
- state SHALL go to IDLE;
- gnt0, gnt1, busy, done, done_id, mul and the accumulator SHALL be 0;
- the round-robin pointer SHALL be set to favour requester 0.
REQ-030 Reset mid-operation SHALL abort the transaction: no done pulse, mul=0.
REQ-031 While rst is high, the grant outputs SHALL remain 0 even with requests pending.

Verification
REQ-032 req0=1, a0=3, b0=5 at T -> gnt0 at T, busy T+1..T+4, done=1 at T+4 with mul=15 and done_id=0.
REQ-033 req1 only, a1=7, b1=15 -> gnt1, done at +4 with mul=105 and done_id=1.
REQ-034 After reset, req0 and req1 both held (a0=5,b0=13; a1=6,b1=11) -> first done mul=65 id=0, then gnt1 at T+5, done mul=66 id=1.
REQ-035 rst asserted at T+2 of a 7x9 job -> no done, mul=0, IDLE next cycle; re-request completes with mul=63.
REQ-036 a0=0, b0=15, and operand change to a0=7 at T+1 -> done at T+4 with mul=0; mul holds 0 while IDLE with no requests.
REQ-037 Exhaustive sweep of all 128 (a,b) pairs via requester 0 -> every mul equals a*b, with done exactly 4 cycles after gnt.
